// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer.
//   - Default geometry (depth, address and data widths).
//   - Drain FSM state encoding.
//   - Buffer entry layout: word address, data and byte enables.
package store_buffer_pkg;

  localparam int unsigned SbDepth = 4;
  localparam int unsigned SbAw    = 32;
  localparam int unsigned SbDw    = 32;

  typedef enum logic [0:0] {
    StIdle,
    StReq
  } drainState_e;

  typedef struct packed {
    logic [SbAw-3:0] wordAddr;
    logic [SbDw-1:0] data;
    logic [3:0]      be;
  } sbEntry_t;

endpackage

// File: rtl/store_buffer_match.sv
// Youngest-match priority encoder over the valid store-buffer entries.
// The valid entries are the ones from head up to head+count-1, oldest first.
// Ports:
//   entAddr/entBe  per-slot word address and byte enables
//   head, count    FIFO head pointer and occupancy
//   ldWordAddr     load word address to compare against
//   hit            some valid entry matches
//   idx            slot of the youngest match
//   fullBe         youngest match writes all four bytes
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SbDepth,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic [SbAw-3:0] entAddr [DEPTH],
  input  logic [3:0]      entBe   [DEPTH],
  input  logic [PW-1:0]   head,
  input  logic [PW:0]     count,
  input  logic [SbAw-3:0] ldWordAddr,
  output logic            hit,
  output logic [PW-1:0]   idx,
  output logic            fullBe
);

  logic [PW-1:0] pos;

  // Walk oldest to youngest; a later match overrides, so the youngest wins.
  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    fullBe = 1'b0;
    pos    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pos = head + PW'(i);
      if ((i < 32'(count)) && (entAddr[pos] == ldWordAddr)) begin
        hit    = 1'b1;
        idx    = pos;
        fullBe = &entBe[pos];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the core memory stage and data memory.
// Stores are accepted one per cycle into a FIFO and drained in order over a
// req/ack handshake; loads are checked against all pending stores.
// Build option: define STORE_BUF_FWD_EN to forward full-word matches to loads;
// otherwise every match raises ld_conflict_o.
// AW/DW must equal the package widths (entry layout is fixed there).
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   st_valid_i/addr/data/be      store from the memory stage
//   st_full_o                    buffer full, core stalls the store
//   ld_valid_i/ld_addr_i         load in the memory stage
//   ld_hit_o/ld_data_o           forwarded load data
//   ld_conflict_o                load must stall until the match drains
//   mem_req_o/addr/data/be       write request to data memory
//   mem_ack_i                    memory accepted current request
//   empty_o                      nothing pending
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SbDepth,
  parameter int unsigned AW    = SbAw,
  parameter int unsigned DW    = SbDw
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid_i,
  input  logic [AW-1:0] st_addr_i,
  input  logic [DW-1:0] st_data_i,
  input  logic [3:0]    st_be_i,
  output logic          st_full_o,
  input  logic          ld_valid_i,
  input  logic [AW-1:0] ld_addr_i,
  output logic          ld_hit_o,
  output logic [DW-1:0] ld_data_o,
  output logic          ld_conflict_o,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_data_o,
  output logic [3:0]    mem_be_o,
  input  logic          mem_ack_i,
  output logic          empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FullCount = (PW+1)'(DEPTH);

  logic [PW-1:0] headQ, tailQ, headNext;
  logic [PW:0]   countQ, countD;
  drainState_e   stateQ, stateD;
  sbEntry_t      memQ, memD;
  sbEntry_t      entries [DEPTH];
  sbEntry_t      newEntry;
  logic          enq, deq;

  logic [SbAw-3:0] entAddr [DEPTH];
  logic [3:0]      entBe   [DEPTH];
  logic            mHit, mFullBe, anyMatch;
  logic [PW-1:0]   mIdx;
  logic            unusedBits;

  assign st_full_o = (countQ == FullCount);
  assign empty_o   = (countQ == '0);
  assign enq       = st_valid_i & ~st_full_o;
  assign deq       = (stateQ == StReq) & mem_ack_i;
  assign headNext  = headQ + 1'b1;

  always_comb begin
    newEntry.wordAddr = st_addr_i[AW-1:2];
    newEntry.data     = st_data_i;
    newEntry.be       = st_be_i;
  end

  always_comb begin
    countD = countQ;
    case ({enq, deq})
      2'b10:   countD = countQ + 1'b1;
      2'b01:   countD = countQ - 1'b1;
      default: countD = countQ;
    endcase
  end

  // Drain FSM: memQ holds the head entry while a request is outstanding.
  always_comb begin
    stateD = stateQ;
    memD   = memQ;
    unique case (stateQ)
      StIdle: begin
        if (countQ != '0) begin
          stateD = StReq;
          memD   = entries[headQ];
        end
      end
      StReq: begin
        if (mem_ack_i) begin
          if (countQ > (PW+1)'(1)) begin
            memD = entries[headNext];
          end else if (enq) begin
            // Last entry acked while a store lands: issue it straight away.
            memD = newEntry;
          end else begin
            stateD = StIdle;
            memD   = '0;
          end
        end
      end
      default: begin
        stateD = StIdle;
        memD   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
      stateQ <= StIdle;
      memQ   <= '0;
    end else begin
      if (enq) tailQ <= tailQ + 1'b1;
      if (deq) headQ <= headNext;
      countQ <= countD;
      stateQ <= stateD;
      memQ   <= memD;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) entries[tailQ] <= newEntry;
  end

  assign mem_req_o  = (stateQ == StReq);
  assign mem_addr_o = {memQ.wordAddr, 2'b00};
  assign mem_data_o = memQ.data;
  assign mem_be_o   = memQ.be;

  for (genvar g = 0; g < DEPTH; g++) begin : gen_ent
    assign entAddr[g] = entries[g].wordAddr;
    assign entBe[g]   = entries[g].be;
  end

  store_buffer_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .entAddr    (entAddr),
    .entBe      (entBe),
    .head       (headQ),
    .count      (countQ),
    .ldWordAddr (ld_addr_i[AW-1:2]),
    .hit        (mHit),
    .idx        (mIdx),
    .fullBe     (mFullBe)
  );

  assign anyMatch = ld_valid_i & mHit;

`ifdef STORE_BUF_FWD_EN
  assign ld_hit_o      = anyMatch & mFullBe;
  assign ld_data_o     = ld_hit_o ? entries[mIdx].data : '0;
  assign ld_conflict_o = anyMatch & ~mFullBe;
  assign unusedBits    = ^{st_addr_i[1:0], ld_addr_i[1:0]};
`else
  assign ld_hit_o      = 1'b0;
  assign ld_data_o     = '0;
  assign ld_conflict_o = anyMatch;
  assign unusedBits    = ^{st_addr_i[1:0], ld_addr_i[1:0], mIdx, mFullBe};
`endif

endmodule
